ay_psg_multi: RTL and testbench

- Parametrised next-generation programmable sound generator.
- CHANNELS tone channels, one shared 17-bit LFSR noise source, per-channel tone/noise mixing, 4-bit volume and a PWM 1-bit output per channel.
- Uses the AY-style address-latch/data-write bus: a0=0 latches the address, a0=1 transfers data.
- Sits on the CPU I/O bus in the clk domain. Its aout bits drive RC-filtered audio pins.

---
 rtl/ay_psg_pkg.sv | 34 +++
 rtl/ay_psg_tone_ch.sv | 45 ++++
 rtl/ay_psg_multi.sv | 169 ++++++++++++++++
 tb/tb_ay_psg_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ay_psg_pkg.sv
// Shared constants and register-map helpers for the ay_psg_multi sound generator.
package ay_psg_pkg;

  localparam int PWM_MAX = 14;
  localparam logic [16:0] LFSR_SEED = 17'h00001;
  localparam int LFSR_TAP_A = 0;
  localparam int LFSR_TAP_B = 3;

  function automatic int tone_lo(input int k);
    return 2 * k;
  endfunction

  function automatic int tone_hi(input int k);
    return 2 * k + 1;
  endfunction

  function automatic int NOISE_OFS(input int c);
    return 2 * c;
  endfunction

  function automatic int TDIS_OFS(input int c);
    return 2 * c + 1;
  endfunction

  function automatic int NDIS_OFS(input int c);
    return 2 * c + 2;
  endfunction

  // Volume registers sit after the mask registers, so their base depends on C.
  function automatic int vol(input int c, input int k);
    return 2 * c + 3 + k;
  endfunction

endpackage

// File: rtl/ay_psg_tone_ch.sv
// One tone channel: period counter plus square-wave toggle, advanced on prescaler ticks.
module ay_psg_tone_ch #(
  parameter int TONE_BITS = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [TONE_BITS-1:0] period,
  output logic                 tone
);

  localparam logic [TONE_BITS-1:0] ONE = {{(TONE_BITS-1){1'b0}}, 1'b1};

  logic [TONE_BITS-1:0] cnt_q, cnt_d;
  logic [TONE_BITS-1:0] limit;
  logic                 tone_q, tone_d;

  // The >= compare lets a shortened period take effect without wrapping the counter.
  always_comb begin
    limit  = (period == '0) ? '0 : period - ONE;
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (tick) begin
      if (cnt_q >= limit) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/ay_psg_multi.sv
// Multi-channel AY-style PSG: tone/noise mixing with PWM volume per channel.
// Optional register readback is enabled by defining PSG_READBACK_EN.
module ay_psg_multi
  import ay_psg_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int PSG_FREQ  = 1789773,
  parameter int CHANNELS  = 3,
  parameter int TONE_BITS = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a0,
  input  logic                wr_tick,
  input  logic [7:0]          wdata,
  input  logic                rd_tick,
  output logic [7:0]          rdata,
  output logic [CHANNELS-1:0] aout
);

  localparam int ACC_W = $clog2(32 * CLK_FREQ);
  localparam logic [ACC_W-1:0] PSG_INC = ACC_W'(PSG_FREQ);
  localparam logic [ACC_W-1:0] WRAP    = ACC_W'(16 * CLK_FREQ);

  logic [7:0]           addr_q, addr_d;
  logic [TONE_BITS-1:0] period_q [CHANNELS];
  logic [TONE_BITS-1:0] period_d [CHANNELS];
  logic [4:0]           noise_per_q, noise_per_d;
  logic [CHANNELS-1:0]  tdis_q, tdis_d;
  logic [CHANNELS-1:0]  ndis_q, ndis_d;
  logic [3:0]           vol_q [CHANNELS];
  logic [3:0]           vol_d [CHANNELS];
  logic [15:0]          tp16;

  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
  logic                 tick;
  logic                 half_q, half_d;
  logic [4:0]           noise_cnt_q, noise_cnt_d, noise_lim;
  logic [16:0]          lfsr_q, lfsr_d;
  logic                 noise;
  logic [3:0]           pwm_q, pwm_d;
  logic [CHANNELS-1:0]  tone, mix;
  logic [CHANNELS-1:0]  aout_q, aout_d;

  always_comb begin
    addr_d      = addr_q;
    period_d    = period_q;
    noise_per_d = noise_per_q;
    tdis_d      = tdis_q;
    ndis_d      = ndis_q;
    vol_d       = vol_q;
    tp16        = '0;
    if (wr_tick && !a0) addr_d = wdata;
    if (wr_tick && a0) begin
      // Each period is edited through a 16-bit view so unimplemented high bits drop out.
      for (int k = 0; k < CHANNELS; k++) begin
        tp16 = 16'(period_q[k]);
        if (addr_q == 8'(tone_lo(k))) tp16[7:0] = wdata;
        if (addr_q == 8'(tone_hi(k))) tp16[15:8] = wdata;
        period_d[k] = TONE_BITS'(tp16);
        if (addr_q == 8'(vol(CHANNELS, k))) vol_d[k] = wdata[3:0];
      end
      if (addr_q == 8'(NOISE_OFS(CHANNELS))) noise_per_d = wdata[4:0];
      if (addr_q == 8'(TDIS_OFS(CHANNELS)))  tdis_d = wdata[CHANNELS-1:0];
      if (addr_q == 8'(NDIS_OFS(CHANNELS)))  ndis_d = wdata[CHANNELS-1:0];
    end
  end

  always_comb begin
    acc_sum     = acc_q + PSG_INC;
    tick        = (acc_sum >= WRAP);
    acc_d       = tick ? (acc_sum - WRAP) : acc_sum;
    half_d      = half_q;
    noise_cnt_d = noise_cnt_q;
    lfsr_d      = lfsr_q;
    noise_lim   = (noise_per_q == 5'd0) ? 5'd0 : noise_per_q - 5'd1;
    if (tick) begin
      half_d = ~half_q;
      if (half_q) begin
        if (noise_cnt_q >= noise_lim) begin
          noise_cnt_d = 5'd0;
          lfsr_d      = {lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B], lfsr_q[16:1]};
        end else begin
          noise_cnt_d = noise_cnt_q + 5'd1;
        end
      end
    end
    pwm_d = (pwm_q == 4'(PWM_MAX)) ? 4'd0 : pwm_q + 4'd1;
  end

  assign noise = lfsr_q[0];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    ay_psg_tone_ch #(.TONE_BITS(TONE_BITS)) u_tone (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .period (period_q[gi]),
      .tone   (tone[gi])
    );
    assign mix[gi]    = (tone[gi] | tdis_q[gi]) & (noise | ndis_q[gi]);
    assign aout_d[gi] = mix[gi] & (pwm_q < vol_q[gi]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      noise_per_q <= '0;
      tdis_q      <= '0;
      ndis_q      <= '0;
      acc_q       <= '0;
      half_q      <= 1'b0;
      noise_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      pwm_q       <= '0;
      aout_q      <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        period_q[k] <= '0;
        vol_q[k]    <= '0;
      end
    end else begin
      addr_q      <= addr_d;
      noise_per_q <= noise_per_d;
      tdis_q      <= tdis_d;
      ndis_q      <= ndis_d;
      acc_q       <= acc_d;
      half_q      <= half_d;
      noise_cnt_q <= noise_cnt_d;
      lfsr_q      <= lfsr_d;
      pwm_q       <= pwm_d;
      aout_q      <= aout_d;
      period_q    <= period_d;
      vol_q       <= vol_d;
    end
  end

  assign aout = aout_q;

`ifdef PSG_READBACK_EN
  logic [7:0] rd_val;
  logic [7:0] rdata_q, rdata_d;

  // Reads see the registered state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < CHANNELS; k++) begin
      if (addr_q == 8'(tone_lo(k)))       rd_val = 8'(16'(period_q[k]));
      if (addr_q == 8'(tone_hi(k)))       rd_val = 8'(16'(period_q[k]) >> 8);
      if (addr_q == 8'(vol(CHANNELS, k))) rd_val = {4'h0, vol_q[k]};
    end
    if (addr_q == 8'(NOISE_OFS(CHANNELS))) rd_val = {3'b000, noise_per_q};
    if (addr_q == 8'(TDIS_OFS(CHANNELS)))  rd_val = 8'(tdis_q);
    if (addr_q == 8'(NDIS_OFS(CHANNELS)))  rd_val = 8'(ndis_q);
    rdata_d = rd_tick ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= 8'h00;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`else
  logic unused_rd;
  assign unused_rd = rd_tick;
  assign rdata     = 8'h00;
`endif

endmodule

// File: tb/tb_ay_psg_multi.sv
// Directed self-checking bench for ay_psg_multi with a prescaler tick on every clk.
module tb_ay_psg_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a0 = 1'b0;
  logic       wr_tick = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_tick = 1'b0;
  logic [7:0] rdata;
  logic [2:0] aout;

  int checks = 0;
  int errors = 0;

  ay_psg_multi #(
    .CLK_FREQ  (1),
    .PSG_FREQ  (16),
    .CHANNELS  (3),
    .TONE_BITS (12)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a0      (a0),
    .wr_tick (wr_tick),
    .wdata   (wdata),
    .rd_tick (rd_tick),
    .rdata   (rdata),
    .aout    (aout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    a0 = a; wdata = d; wr_tick = 1'b1;
    step();
    wr_tick = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] ad, input logic [7:0] d);
    wr(1'b0, ad);
    wr(1'b1, d);
  endtask

  task automatic rd();
    rd_tick = 1'b1;
    step();
    rd_tick = 1'b0;
  endtask

  // Edges until aout[0] changes; -1 if the bound expires.
  task automatic wait_toggle(input int limit, output int edges);
    logic prev;
    prev = aout[0];
    edges = 0;
    do begin
      step();
      edges++;
    end while (aout[0] == prev && edges < limit);
    if (aout[0] == prev) edges = -1;
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (aout[0]) c++;
    end
  endtask

  function automatic logic [16:0] lfsr_after(input int m);
    logic [16:0] s;
    s = 17'h00001;
    for (int i = 0; i < m / 2; i++) s = {s[0] ^ s[3], s[16:1]};
    return s;
  endfunction

  initial begin
    int e;
    int c;
    logic [16:0] model;

    #2;
    check("reset_aout", 32'(aout), 32'h0);
    check("reset_rdata", 32'(rdata), 32'h0);
    step(); step();
    reset = 1'b1;

`ifdef PSG_READBACK_EN
    reg_wr(8'd1, 8'hFF); rd();
    check("rd_tone_hi_mask", 32'(rdata), 32'h0F);
    reg_wr(8'd0, 8'hA5); rd();
    check("rd_tone_lo", 32'(rdata), 32'hA5);
    reg_wr(8'd12, 8'h55); rd();
    check("rd_out_of_map", 32'(rdata), 32'h00);
    reg_wr(8'd6, 8'hFF); rd();
    check("rd_noise_mask", 32'(rdata), 32'h1F);
    reg_wr(8'd7, 8'hFF); rd();
    check("rd_tdis_mask", 32'(rdata), 32'h07);
    reg_wr(8'd9, 8'h07); rd();
    check("rd_vol0", 32'(rdata), 32'h07);
    a0 = 1'b1; wdata = 8'h03; wr_tick = 1'b1; rd_tick = 1'b1;
    step();
    wr_tick = 1'b0; rd_tick = 1'b0;
    check("rd_same_cycle_prewrite", 32'(rdata), 32'h07);
    step(); step();
    check("rd_hold", 32'(rdata), 32'h07);
    rd();
    check("rd_after_write", 32'(rdata), 32'h03);
`else
    reg_wr(8'd1, 8'hFF); rd();
    check("rd_tied_zero", 32'(rdata), 32'h00);
`endif

    // PWM volume with the mix forced high
    reg_wr(8'd7, 8'hFF);
    reg_wr(8'd8, 8'hFF);
    reg_wr(8'd9, 8'h04);
    step(); step();
    count_high(15, c);
    check("pwm_vol4_a", 32'(c), 32'd4);
    count_high(15, c);
    check("pwm_vol4_b", 32'(c), 32'd4);
    check("pwm_ch1_vol0", 32'(aout[1]), 32'h0);
    reg_wr(8'd9, 8'h0F);
    step(); step();
    count_high(15, c);
    check("pwm_vol15", 32'(c), 32'd15);
    reg_wr(8'd9, 8'h00);
    step(); step();
    count_high(15, c);
    check("pwm_vol0", 32'(c), 32'd0);

    // Tone rate: period 5 toggles every 5 ticks
    reg_wr(8'd0, 8'd5);
    reg_wr(8'd1, 8'd0);
    reg_wr(8'd7, 8'hFE);
    reg_wr(8'd9, 8'h0F);
    step(); step();
    wait_toggle(50, e);
    check("tone5_sync", 32'(e > 0), 32'h1);
    for (int i = 0; i < 3; i++) begin
      wait_toggle(50, e);
      check("tone5_interval", 32'(e), 32'd5);
    end

    // Period lowered from 100 to 10 with the counter at 50
    reg_wr(8'd0, 8'd100);
    wait_toggle(300, e);
    check("tone100_sync", 32'(e > 0), 32'h1);
    wait_toggle(300, e);
    check("tone100_interval", 32'(e), 32'd100);
    for (int i = 0; i < 48; i++) step();
    wr(1'b1, 8'd10);
    wait_toggle(50, e);
    check("tone_shorten_next_tick", 32'(e), 32'd2);
    wait_toggle(50, e);
    check("tone10_interval_a", 32'(e), 32'd10);
    wait_toggle(50, e);
    check("tone10_interval_b", 32'(e), 32'd10);

    // Asynchronous reset while the tone output is high
    if (aout[0] == 1'b0) wait_toggle(50, e);
    check("pre_reset_aout_high", 32'(aout[0]), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_aout", 32'(aout), 32'h0);
    check("async_reset_rdata", 32'(rdata), 32'h0);
    step();
    reset = 1'b1;

    // Noise on ch0 only; the LFSR advances on every second tick from reset
    reg_wr(8'd6, 8'd1);
    reg_wr(8'd7, 8'hFF);
    reg_wr(8'd8, 8'hFE);
    reg_wr(8'd9, 8'h0F);
    for (int n = 9; n <= 80; n++) begin
      step();
      model = lfsr_after(n - 1);
      check($sformatf("noise_n%0d", n), 32'(aout[0]), 32'(model[0]));
    end
    check("noise_other_ch_silent", 32'(aout[2:1]), 32'h0);

`ifdef PSG_READBACK_EN
    reg_wr(8'd0, 8'h00);
    rd();
    check("post_reset_period_lo", 32'(rdata), 32'h00);
    wr(1'b0, 8'd1);
    rd();
    check("post_reset_period_hi", 32'(rdata), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
